// File: rtl/standard_alu_comb_if.sv
// Operand/result bundle for the 16-bit pipelined ALU.
// The ALU side is the slave: it consumes operands and drives the three results.
interface standard_alu_comb_if;
  logic [15:0] io_in_x;
  logic [15:0] io_in_y;
  logic        io_in_carry;
  logic        io_in_select;
  logic [15:0] io_in_mask;
  logic [3:0]  io_funct;
  logic [15:0] io_out;
  logic [31:0] io_mul_out;
  logic        io_carry_out;

  modport master (
    output io_in_x, io_in_y, io_in_carry, io_in_select, io_in_mask, io_funct,
    input  io_out, io_mul_out, io_carry_out
  );

  modport slave (
    input  io_in_x, io_in_y, io_in_carry, io_in_select, io_in_mask, io_funct,
    output io_out, io_mul_out, io_carry_out
  );
endinterface

// File: rtl/standard_alu_comb.sv
// 16-bit three-stage ALU: operand register, compute register, output register.
// One operation per cycle, no handshake; every field of an operation moves in lockstep.
module standard_alu_comb (
  input  logic                clock,
  input  logic                reset,
  standard_alu_comb_if.slave  alu
);

  typedef enum logic [3:0] {
    F_ADD  = 4'd0,  F_SUB  = 4'd1,  F_MUL  = 4'd2,  F_MULH = 4'd3,
    F_MULS = 4'd4,  F_AND  = 4'd5,  F_OR   = 4'd6,  F_XOR  = 4'd7,
    F_SLL  = 4'd8,  F_SRL  = 4'd9,  F_SRA  = 4'd10, F_SEQ  = 4'd11,
    F_SLTU = 4'd12, F_SLTS = 4'd13, F_MUX  = 4'd14, F_ADDC = 4'd15
  } funct_e;

  // Stage 1: operand registers
  logic [15:0] x_q, y_q, mask_q;
  logic        carry_q, select_q;
  funct_e      funct_q;

  // Stage 2: compute registers
  logic [15:0] res_q, mask2_q;
  logic [31:0] mul_q;
  logic        co_q;

  // Stage 3: output registers
  logic [15:0] out_q;
  logic [31:0] mul_out_q;
  logic        co_out_q;

  logic [15:0] res_d;
  logic [31:0] mul_d;
  logic        co_d;
  logic [31:0] prod_u;
  logic [31:0] prod_s;
  logic [16:0] add17;
  logic [16:0] addc17;
  logic [3:0]  shamt;

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      mask_q   <= '0;
      carry_q  <= 1'b0;
      select_q <= 1'b0;
      funct_q  <= F_ADD;
    end else begin
      x_q      <= alu.io_in_x;
      y_q      <= alu.io_in_y;
      mask_q   <= alu.io_in_mask;
      carry_q  <= alu.io_in_carry;
      select_q <= alu.io_in_select;
      funct_q  <= funct_e'(alu.io_funct);
    end
  end

  // Signed product uses explicit sign extension so the low 32 bits are the exact product.
  assign prod_u = {16'b0, x_q} * {16'b0, y_q};
  assign prod_s = {{16{x_q[15]}}, x_q} * {{16{y_q[15]}}, y_q};
  assign add17  = {1'b0, x_q} + {1'b0, y_q};
  assign addc17 = {1'b0, x_q} + {1'b0, y_q} + {16'b0, carry_q};
  assign shamt  = y_q[3:0];

  always_comb begin
    res_d = '0;
    mul_d = '0;
    co_d  = 1'b0;
    unique case (funct_q)
      F_ADD: begin
        res_d = add17[15:0];
        co_d  = add17[16];
      end
      F_SUB:  res_d = x_q - y_q;
      F_MUL: begin
        res_d = prod_u[15:0];
        mul_d = prod_u;
      end
      F_MULH: begin
        res_d = prod_u[31:16];
        mul_d = prod_u;
      end
      F_MULS: begin
        res_d = prod_s[15:0];
        mul_d = prod_s;
      end
      F_AND:  res_d = x_q & y_q;
      F_OR:   res_d = x_q | y_q;
      F_XOR:  res_d = x_q ^ y_q;
      F_SLL:  res_d = x_q << shamt;
      F_SRL:  res_d = x_q >> shamt;
      F_SRA:  res_d = $unsigned($signed(x_q) >>> shamt);
      F_SEQ:  res_d = {15'b0, x_q == y_q};
      F_SLTU: res_d = {15'b0, x_q < y_q};
      F_SLTS: res_d = {15'b0, $signed(x_q) < $signed(y_q)};
      F_MUX:  res_d = select_q ? y_q : x_q;
      F_ADDC: begin
        res_d = addc17[15:0];
        co_d  = addc17[16];
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q   <= '0;
      mul_q   <= '0;
      co_q    <= 1'b0;
      mask2_q <= '0;
    end else begin
      res_q   <= res_d;
      mul_q   <= mul_d;
      co_q    <= co_d;
      mask2_q <= mask_q;
    end
  end

  // The mask rides along with its own operation and is applied on the way out.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= '0;
      mul_out_q <= '0;
      co_out_q  <= 1'b0;
    end else begin
      out_q     <= res_q & mask2_q;
      mul_out_q <= mul_q;
      co_out_q  <= co_q;
    end
  end

  assign alu.io_out       = out_q;
  assign alu.io_mul_out   = mul_out_q;
  assign alu.io_carry_out = co_out_q;

endmodule

// File: tb/tb_standard_alu_comb.sv
// Bench for standard_alu_comb: directed corner cases, mid-flight reset and a
// 2000-operation random regression against an integer-arithmetic reference model.
module tb_standard_alu_comb;

  logic clock;
  logic reset;
  standard_alu_comb_if alu_if ();

  standard_alu_comb dut (
    .clock (clock),
    .reset (reset),
    .alu   (alu_if.slave)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    string       tag;
    logic [15:0] out;
    logic [31:0] mul;
    logic        co;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   total;
  int   bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic straight from the function table.
  function automatic void ref_model(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y,
                                    input logic c, input logic s, input logic [15:0] m,
                                    output logic [15:0] o, output logic [31:0] mo, output logic co);
    longint ux, uy, sx, sy, r, p;
    int     n;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    n  = int'(uy % 16);
    r  = 0;
    mo = '0;
    co = 1'b0;
    case (f)
      4'd0:  begin r = ux + uy; co = (r >= 65536); end
      4'd1:  r = ux - uy;
      4'd2:  begin p = ux * uy; mo = 32'(p); r = p; end
      4'd3:  begin p = ux * uy; mo = 32'(p); r = p / 65536; end
      4'd4:  begin p = sx * sy; mo = 32'(p); r = p; end
      4'd5:  r = ux & uy;
      4'd6:  r = ux | uy;
      4'd7:  r = ux ^ uy;
      4'd8:  r = ux * (longint'(1) << n);
      4'd9:  r = ux / (longint'(1) << n);
      4'd10: r = sx >>> n;
      4'd11: r = (ux == uy) ? 1 : 0;
      4'd12: r = (ux < uy) ? 1 : 0;
      4'd13: r = (sx < sy) ? 1 : 0;
      4'd14: r = s ? uy : ux;
      default: begin r = ux + uy + longint'(c); co = (r >= 65536); end
    endcase
    o = 16'(r) & m;
  endfunction

  // driver task: one operation per call, one call per cycle
  task automatic issue(input string tag, input logic [3:0] f, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic s, input logic [15:0] m, input bit chk);
    exp_t e;
    @(negedge clock);
    alu_if.io_funct     = f;
    alu_if.io_in_x      = x;
    alu_if.io_in_y      = y;
    alu_if.io_in_carry  = c;
    alu_if.io_in_select = s;
    alu_if.io_in_mask   = m;
    if (chk) begin
      e.due = cyc + 3;
      e.tag = tag;
      ref_model(f, x, y, c, s, m, e.out, e.mul, e.co);
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_zero(input string tag, input int due);
    exp_t e;
    e.due = due;
    e.tag = tag;
    e.out = '0;
    e.mul = '0;
    e.co  = 1'b0;
    exp_q.push_back(e);
  endtask

  // scoreboard: compare each expectation on the edge it is due, 1 time unit after the edge
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    #1;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".due"}, 32'(e.due), 32'(cyc));
      check_eq({e.tag, ".out"}, {16'b0, alu_if.io_out}, {16'b0, e.out});
      check_eq({e.tag, ".mul"}, alu_if.io_mul_out, e.mul);
      check_eq({e.tag, ".co"},  {31'b0, alu_if.io_carry_out}, {31'b0, e.co});
    end
  end

  function automatic logic [15:0] pick16();
    logic [15:0] corners [6];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h00FF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    cyc   = 0;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    alu_if.io_funct     = '0;
    alu_if.io_in_x      = '0;
    alu_if.io_in_y      = '0;
    alu_if.io_in_carry  = 1'b0;
    alu_if.io_in_select = 1'b0;
    alu_if.io_in_mask   = '0;
    expect_zero("reset0", 1);
    expect_zero("reset1", 2);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    issue("lat_add",  4'd0,  16'h0001, 16'h0002, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("lat_xor",  4'd7,  16'hFFFF, 16'h00FF, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("addc_co",  4'd15, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    issue("addc_nc",  4'd15, 16'h1234, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("add_co",   4'd0,  16'h8000, 16'h8001, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    issue("sub_wrap", 4'd1,  16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("mul_ff",   4'd2,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("mulh_ff",  4'd3,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("mulh_sh",  4'd3,  16'h1234, 16'h0010, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("muls_neg", 4'd4,  16'hFFFF, 16'h0003, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("sll_hi",   4'd8,  16'h0001, 16'hFFF4, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("srl_15",   4'd9,  16'h8000, 16'h000F, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("sra_3",    4'd10, 16'h8000, 16'h0003, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("seq_ne",   4'd11, 16'h8003, 16'h0003, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("sltu",     4'd12, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("slts",     4'd13, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    issue("mux_y",    4'd14, 16'hAAAA, 16'h5555, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    issue("mux_x",    4'd14, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    issue("and_mask", 4'd5,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h00FF, 1'b1);
    issue("or_mask",  4'd6,  16'h0F0F, 16'hF000, 1'b0, 1'b0, 16'hFF00, 1'b1);

    // Two operations in flight when reset hits: both must vanish.
    issue("flight0",  4'd2,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    issue("flight1",  4'd0,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    expect_zero("rst_r0", cyc + 1);
    expect_zero("rst_r1", cyc + 2);
    expect_zero("rst_r2", cyc + 3);
    @(negedge clock);
    reset = 1'b0;
    issue("post_rst", 4'd0,  16'h0001, 16'h0002, 1'b0, 1'b0, 16'hFFFF, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      issue("rand", 4'($urandom_range(0, 15)), pick16(), pick16(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'hFFFF, 1'b1);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/standard_alu_comb.md
# standard_alu_comb

16-bit pipelined ALU for the core datapath, organised like a DSP48 slice: registered operands, one compute stage, registered outputs. Each cycle it takes two operands plus carry, select and mask, and one of 16 function codes, and produces a 16-bit result, a 32-bit multiply result and a carry-out. It is fully pipelined with no valid/ready handshake: a new operation may be issued every cycle.

## Interface
- Parameters: none. Data width is fixed at 16 bits and the multiply width at 32 bits.
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all pipeline registers
- io_in_x  in  16  operand x (op1)
- io_in_y  in  16  operand y (op2); the shift amount is y[3:0]
- io_in_carry  in  1  carry-in, used by ADDC only
- io_in_select  in  1  MUX select: 1 selects y, 0 selects x
- io_in_mask  in  16  result mask, ANDed onto io_out
- io_funct  in  4  function code, listed under Operation
- io_out  out  16  primary result
- io_mul_out  out  32  full multiply product
- io_carry_out  out  1  carry-out

## Operation
- Function codes:
  - ADD=0, SUB=1, MUL=2, MULH=3, MULS=4, AND=5, OR=6, XOR=7
  - SLL=8, SRL=9, SRA=10, SEQ=11, SLTU=12, SLTS=13, MUX=14, ADDC=15
- The raw result r is computed per function; io_out = r & io_in_mask, using the mask from the same operation.
- Add / subtract (all mod 2^16):
  - ADD: r = x + y.
  - SUB: r = x − y.
  - ADDC: {co, r} = x + y + carry, computed 17 bits wide.
- Multiply:
  - MUL: r = low 16 bits of unsigned x·y; mul_out = unsigned 32-bit x·y.
  - MULH: mul_out = unsigned 32-bit x·y; r = mul_out[31:16].
  - MULS: mul_out = signed 32-bit x·y (two's complement); r = mul_out[15:0].
- Logic: AND, OR, XOR are bitwise on x and y.
- Shifts, by y[3:0]; y[15:4] is ignored:
  - SLL: r = x << y[3:0].
  - SRL: r = x >> y[3:0], zero-fill.
  - SRA: r = x >>> y[3:0], sign-fill from x[15].
- Compare and select:
  - SEQ: r = {15'b0, x==y}.
  - SLTU: r = {15'b0, x<y}, unsigned compare.
  - SLTS: r = {15'b0, $signed(x)<$signed(y)}.
  - MUX: r = select ? y : x.
- io_carry_out:
  - ADDC: bit 16 of the ADDC sum.
  - ADD: bit 16 of x + y.
  - All other functions: 0.
- io_mul_out is 0 for all non-multiply functions.
- Signals belonging to one operation travel together through the pipeline, so outputs never mix operands from different cycles.

## Timing
- Latency is 3 register stages:
  - Stage 1: inputs sampled at rising edge N.
  - Stage 2: compute/multiply register at edge N+1.
  - Stage 3: output register at edge N+2.
- io_out, io_mul_out and io_carry_out show operation N after edge N+2 and hold until edge N+3.
- Throughput is one operation per cycle; back-to-back operations with arbitrary funct mixes are required.
- All outputs are driven directly from registers; there is no combinational input→output path.
- Reset (synchronous): while reset is high at an edge, all stages load 0.
  - io_out, io_mul_out and io_carry_out read 0 starting 1 cycle after the reset edge.
  - Operations in flight are discarded.
  - Operations issued on the cycle reset deasserts are processed normally.
- Power-up without reset: outputs are undefined until 3 edges after the first valid input. Integrators either hold reset or ignore the first 3 cycles.

## Test plan
- Pipeline/latency: issue ADD 0x0001+0x0002 at edge N, then XOR 0xFFFF^0x00FF at N+1. Required: io_out = 0x0003 after N+2 and 0xFF00 after N+3; no bubbles.
- Arithmetic/carry:
  - ADDC 0xFFFF+0x0000+1 → io_out 0x0000, carry_out 1.
  - ADDC 0x1234+0x0001+0 → io_out 0x1235, carry_out 0.
  - SUB 0x0000−0x0001 → 0xFFFF.
- Multiply:
  - MUL 0xFFFF·0xFFFF → io_out 0x0001.
  - MULH 0xFFFF·0xFFFF → io_mul_out 0xFFFE0001.
  - MULH 0x1234·0x0010 → io_mul_out 0x00012340.
- Shifts, y upper bits ignored:
  - SLL 0x0001 by y=0xFFF4 → 0x0010.
  - SRL 0x8000 by 0x000F → 0x0001.
  - SRA 0x8000 by 0x0003 → 0xF000.
- Compares/mux:
  - SEQ 0x8003 vs 0x0003 → 0.
  - SLTU 0x8000<0x0001 → 0.
  - SLTS 0x8000<0x0001 → 1.
  - MUX sel=1, x=0xAAAA, y=0x5555 → 0x5555.
- Mask/reset:
  - AND 0xFFFF&0xFFFF with mask 0x00FF → 0x00FF.
  - Assert reset with 2 ops in flight → all outputs 0 on the following cycles.
  - Random regression of 2000 mixed operations with mask 0xFFFF: every result matches the reference model.
